// File: rtl/pc_gen.sv
// Fetch program-counter generator with trap/redirect/stall control and a
// circular return-address stack for call/return target prediction.
module pc_gen #(
    parameter int unsigned     XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INC          = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         trap_valid,
    input  logic [XLEN-1:0]              trap_vector,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_target,
    input  logic                         call,
    input  logic [XLEN-1:0]              call_target,
    input  logic                         ret,
    output logic [XLEN-1:0]              pc_out,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_underflow
);

    localparam int unsigned     PW    = $clog2(RAS_DEPTH);
    localparam int unsigned     CW    = PW + 1;
    localparam logic [CW-1:0]   FULL  = CW'(RAS_DEPTH);
    localparam logic [XLEN-1:0] INC_X = XLEN'(INC);

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] pc_q, pc_d, seq_pc;
    logic [PW-1:0]   sp_q, sp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            uf_q, uf_d;
    logic            push_en;

    assign seq_pc = pc_q + INC_X;

    always_comb begin
        pc_d    = seq_pc;
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        uf_d    = 1'b0;
        push_en = 1'b0;
        if (trap_valid) begin
            pc_d  = trap_vector;
            sp_d  = '0;
            cnt_d = '0;
        end else if (redirect_valid) begin
            pc_d = redirect_target;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            // ret takes precedence over a simultaneous call
            if (cnt_q != '0) begin
                pc_d  = ras_q[sp_q];
                sp_d  = sp_q - PW'(1);
                cnt_d = cnt_q - CW'(1);
            end else begin
                uf_d = 1'b1;
            end
        end else if (call) begin
            pc_d    = call_target;
            sp_d    = sp_q + PW'(1);
            push_en = 1'b1;
            // when full the push silently overwrites the oldest entry
            if (cnt_q != FULL) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            sp_q  <= '0;
            cnt_q <= '0;
            uf_q  <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            uf_q  <= uf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !reset) begin
            ras_q[sp_d] <= seq_pc;
        end
    end

    assign pc_out        = pc_q;
    assign ras_count     = cnt_q;
    assign ras_underflow = uf_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: each stimulus cycle queues its expected
// registered outputs; a monitor pops and compares on the falling edge.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        trap_valid = 1'b0;
    logic [63:0] trap_vector = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_target = '0;
    logic        call = 1'b0;
    logic [63:0] call_target = '0;
    logic        ret = 1'b0;
    logic [63:0] pc_out;
    logic [2:0]  ras_count;
    logic        ras_underflow;

    typedef struct {
        int          id;
        logic [63:0] pc;
        logic [2:0]  cnt;
        logic        uf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    pc_gen #(
        .XLEN        (64),
        .RESET_VECTOR(64'h1000),
        .INC         (4),
        .RAS_DEPTH   (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .trap_valid     (trap_valid),
        .trap_vector    (trap_vector),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .call           (call),
        .call_target    (call_target),
        .ret            (ret),
        .pc_out         (pc_out),
        .ras_count      (ras_count),
        .ras_underflow  (ras_underflow)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are registered, so the falling edge sees settled values.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (pc_out !== e.pc || ras_count !== e.cnt || ras_underflow !== e.uf) begin
                errors++;
                $display("FAIL step%0d: got pc=%h cnt=%0d uf=%b, required pc=%h cnt=%0d uf=%b",
                         e.id, pc_out, ras_count, ras_underflow, e.pc, e.cnt, e.uf);
            end
        end
    end

    task automatic drive(input logic rs, input logic st, input logic tv, input logic [63:0] tvec,
                         input logic rv, input logic [63:0] rtgt, input logic c,
                         input logic [63:0] ctgt, input logic r,
                         input logic [63:0] e_pc, input logic [2:0] e_cnt, input logic e_uf);
        exp_t e;
        @(negedge clk);
        reset = rs; stall = st; trap_valid = tv; trap_vector = tvec;
        redirect_valid = rv; redirect_target = rtgt; call = c; call_target = ctgt; ret = r;
        @(posedge clk);
        #1;
        e.id = step_id; e.pc = e_pc; e.cnt = e_cnt; e.uf = e_uf;
        sb.push_back(e);
        step_id++;
    endtask

    task automatic t_idle(input logic [63:0] p, input logic [2:0] n);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, p, n, 0);
    endtask
    task automatic t_call(input logic [63:0] tgt, input logic [63:0] p, input logic [2:0] n);
        drive(0, 0, 0, 0, 0, 0, 1, tgt, 0, p, n, 0);
    endtask
    task automatic t_ret(input logic [63:0] p, input logic [2:0] n, input logic u);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, p, n, u);
    endtask
    task automatic t_redir(input logic [63:0] tgt, input logic [2:0] n);
        drive(0, 0, 0, 0, 1, tgt, 0, 0, 0, tgt, n, 0);
    endtask

    initial begin
        // Reset and sequential fetch
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h1000, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h1000, 0, 0);
        t_idle(64'h1004, 0);
        t_idle(64'h1008, 0);
        // Stall with call pulsed: everything holds
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0, 1, 64'h9000, 0, 64'h1008, 0, 0);
        t_idle(64'h100C, 0);
        t_idle(64'h1010, 0);

        // Call/return nesting
        t_redir(64'h2000, 0);
        t_call(64'h3000, 64'h3000, 1);
        t_call(64'h4000, 64'h4000, 2);
        t_idle(64'h4004, 2);
        t_ret(64'h3004, 1, 0);
        t_idle(64'h3008, 1);
        t_ret(64'h2004, 0, 0);

        // Overflow: 5th push overwrites the oldest (0x2008)
        t_call(64'h100, 64'h100, 1);
        t_call(64'h200, 64'h200, 2);
        t_call(64'h300, 64'h300, 3);
        t_call(64'h400, 64'h400, 4);
        t_call(64'h500, 64'h500, 4);
        t_ret(64'h404, 3, 0);
        t_ret(64'h304, 2, 0);
        t_ret(64'h204, 1, 0);
        t_ret(64'h104, 0, 0);
        t_ret(64'h108, 0, 1);
        t_idle(64'h10C, 0);

        // Priority: trap beats redirect, stall and ret
        t_call(64'h600, 64'h600, 1);
        t_call(64'h700, 64'h700, 2);
        drive(0, 1, 1, 64'h8000, 1, 64'h5000, 0, 0, 1, 64'h8000, 0, 0);
        t_call(64'h600, 64'h600, 1);
        t_call(64'h700, 64'h700, 2);
        drive(0, 1, 0, 0, 1, 64'h5000, 0, 0, 1, 64'h5000, 2, 0);
        t_ret(64'h604, 1, 0);
        t_ret(64'h8004, 0, 0);

        // call and ret together: ret wins, no push
        t_call(64'hA000, 64'hA000, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 64'hB000, 1, 64'h8008, 0, 0);
        t_ret(64'h800C, 0, 1);

        // Wrap-around
        t_redir(64'hFFFF_FFFF_FFFF_FFFC, 0);
        t_idle(64'h0, 0);
        t_redir(64'hFFFF_FFFF_FFFF_FFFC, 0);
        t_call(64'h10, 64'h10, 1);
        t_ret(64'h0, 0, 0);

        // Reset mid-sequence wins and empties the RAS
        t_call(64'h20, 64'h20, 1);
        drive(1, 0, 0, 0, 0, 0, 1, 64'h30, 0, 64'h1000, 0, 0);
        t_ret(64'h1004, 0, 1);
        t_idle(64'h1008, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
